// File: rtl/seg_scan_if.sv
// Load/display bundle for the multiplexed 4-digit BCD scan controller.
interface seg_scan_if;
  logic        load;
  logic [15:0] din;
  logic        x;
  logic        y;
  logic        z;
  logic        w;
  logic [3:0]  digit;
  logic        err;

  modport master (output load, din, input x, y, z, w, digit, err);
  modport slave  (input load, din, output x, y, z, w, digit, err);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit BCD display scanner with anti-ghost blanking.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int unsigned PW = 16;

  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_nxt;
  logic [15:0]   r_val;
  logic [15:0]   w_val_nxt;
  logic [3:0]    r_nib;
  logic [3:0]    w_nib_nxt;
  logic [3:0]    r_dig;
  logic [3:0]    w_dig_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          w_wrap;
  logic          w_blank;
  logic          w_lzb;

  // Next-state and next-output logic; outputs derive from current held value/index.
  always_comb begin
    w_val_nxt = bus.load ? bus.din : r_val;
    w_wrap    = (r_pre == PW'(REFRESH_DIV - 1));
    w_pre_nxt = w_wrap ? '0 : r_pre + PW'(1);
    w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;
    w_blank   = (r_pre < PW'(BLANK_CYC));

    case (r_idx)
      2'd0:    w_nib_nxt = r_val[3:0];
      2'd1:    w_nib_nxt = r_val[7:4];
      2'd2:    w_nib_nxt = r_val[11:8];
      default: w_nib_nxt = r_val[15:12];
    endcase

`ifdef SEG_SCAN_LZB_EN
    // A digit is a leading zero when it and every higher nibble are zero.
    case (r_idx)
      2'd0:    w_lzb = 1'b0;
      2'd1:    w_lzb = (r_val[15:4] == 12'd0);
      2'd2:    w_lzb = (r_val[15:8] == 8'd0);
      default: w_lzb = (r_val[15:12] == 4'd0);
    endcase
`else
    w_lzb = 1'b0;
`endif

    w_dig_nxt = 4'b0000;
    if (!w_blank && (w_nib_nxt <= 4'd9) && !w_lzb) begin
      w_dig_nxt = 4'b0001 << r_idx;
    end

    w_err_nxt = (r_val[3:0] > 4'd9) || (r_val[7:4] > 4'd9) ||
                (r_val[11:8] > 4'd9) || (r_val[15:12] > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= '0;
      r_pre <= '0;
      r_idx <= '0;
      r_nib <= '0;
      r_dig <= '0;
      r_err <= 1'b0;
    end else begin
      r_val <= w_val_nxt;
      r_pre <= w_pre_nxt;
      r_idx <= w_idx_nxt;
      r_nib <= w_nib_nxt;
      r_dig <= w_dig_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign bus.x     = r_nib[3];
  assign bus.y     = r_nib[2];
  assign bus.z     = r_nib[1];
  assign bus.w     = r_nib[0];
  assign bus.digit = r_dig;
  assign bus.err   = r_err;

endmodule
